// File: rtl/npc_sequencer.sv
// SPARC PC/nPC sequencer: delayed control transfer with delay slot, annul bit and JMPL redirect.
// Optional build macro NPC_ALIGN_CHECK_EN drops misaligned redirect targets and raises a sticky misalign flag.
module npc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        br_always,
  input  logic        br_annul,
  input  logic [31:0] br_target,
  input  logic        jmpl_valid,
  input  logic [31:0] jmpl_target,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic        annul_out,
  output logic        misalign
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SLOT   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic [31:0] w_npc_next;
  logic [31:0] w_npc_inc;
  logic [31:0] w_target;
  logic        w_cti_en;
  logic        w_jmpl_acc;
  logic        w_br_acc;
  logic        w_redirect;
  logic        w_annul_slot;
  logic        w_target_bad;

  // An annulled delay slot must not redirect, so all CTI qualifiers are gated off in SQUASH.
  always_comb begin
    w_cti_en     = (r_state != ST_SQUASH);
    w_jmpl_acc   = jmpl_valid & w_cti_en;
    w_br_acc     = br_valid & w_cti_en;
    w_npc_inc    = r_npc + 32'd4;
    w_redirect   = w_jmpl_acc | (w_br_acc & br_taken);
    w_target     = w_jmpl_acc ? jmpl_target : br_target;
    w_annul_slot = w_br_acc & br_annul & (~br_taken | br_always);
`ifdef NPC_ALIGN_CHECK_EN
    w_target_bad = w_redirect & (w_target[1:0] != 2'b00);
`else
    w_target_bad = 1'b0;
`endif
    w_npc_next   = (w_redirect & ~w_target_bad) ? w_target : w_npc_inc;
  end

  always_comb begin
    w_state_next = ST_RUN;
    case (r_state)
      ST_RUN, ST_SLOT: begin
        if (w_annul_slot)
          w_state_next = ST_SQUASH;
        else if (w_br_acc | w_jmpl_acc)
          w_state_next = ST_SLOT;
        else
          w_state_next = ST_RUN;
      end
      ST_SQUASH: w_state_next = ST_RUN;
      default:   w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_npc   <= RESET_PC + 32'd4;
    end else if (!stall) begin
      r_state <= w_state_next;
      r_pc    <= r_npc;
      r_npc   <= w_npc_next;
    end
  end

`ifdef NPC_ALIGN_CHECK_EN
  logic r_misalign;

  // Sticky until reset; a stalled edge leaves it untouched like the rest of the state.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_misalign <= 1'b0;
    else if (!stall)
      r_misalign <= r_misalign | w_target_bad;
  end

  assign misalign = r_misalign;
`else
  assign misalign = w_target_bad;
`endif

  assign pc_out    = r_pc;
  assign npc_out   = r_npc;
  assign annul_out = (r_state == ST_SQUASH);

endmodule

// File: tb/tb_npc_sequencer.sv
// Self-checking bench for npc_sequencer: directed vector table plus random stimulus against a
// fetch-stream reference model (pc/npc pair and an "annulled" flag).
module tb_npc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic        br_always;
  logic        br_annul;
  logic [31:0] br_target;
  logic        jmpl_valid;
  logic [31:0] jmpl_target;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic        annul_out;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  npc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .br_always  (br_always),
    .br_annul   (br_annul),
    .br_target  (br_target),
    .jmpl_valid (jmpl_valid),
    .jmpl_target(jmpl_target),
    .pc_out     (pc_out),
    .npc_out    (npc_out),
    .annul_out  (annul_out),
    .misalign   (misalign)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic        stall;
    logic        bv;
    logic        bt;
    logic        ba;
    logic        bn;
    logic [31:0] btgt;
    logic        jv;
    logic [31:0] jtgt;
    logic [31:0] exp_pc;
    logic [31:0] exp_npc;
    logic        exp_annul;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  // inputs: rst_n stall bv bt balways bannul btgt jv jtgt ; expected pc npc annul misalign
  function automatic vec_t mk(string nm, logic r, logic s, logic bv, logic bt, logic ba, logic bn,
                              logic [31:0] btgt, logic jv, logic [31:0] jtgt,
                              logic [31:0] epc, logic [31:0] enpc, logic ean, logic emis);
    vec_t v;
    v.name = nm; v.rst_n = r; v.stall = s; v.bv = bv; v.bt = bt; v.ba = ba; v.bn = bn;
    v.btgt = btgt; v.jv = jv; v.jtgt = jtgt;
    v.exp_pc = epc; v.exp_npc = enpc; v.exp_annul = ean; v.exp_mis = emis;
    return v;
  endfunction

  task automatic check32(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic check1(string nm, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic s, logic bv, logic bt, logic ba, logic bn,
                       logic [31:0] btgt, logic jv, logic [31:0] jtgt);
    rst_n = r; stall = s; br_valid = bv; br_taken = bt; br_always = ba; br_annul = bn;
    br_target = btgt; jmpl_valid = jv; jmpl_target = jtgt;
  endtask

  // Reference model: the fetch stream as (pc, npc) plus whether the current fetch is annulled.
  logic [31:0] m_pc, m_npc;
  logic        m_annul, m_mis;

  task automatic model_edge(logic r, logic s, logic bv, logic bt, logic ba, logic bn,
                            logic [31:0] btgt, logic jv, logic [31:0] jtgt);
    logic        can_redirect;
    logic        redirect;
    logic [31:0] tgt;
    logic [31:0] new_npc;
    if (!r) begin
      m_pc = 32'h0; m_npc = 32'h4; m_annul = 1'b0; m_mis = 1'b0;
      return;
    end
    if (s) return;
    can_redirect = !m_annul;
    redirect = 1'b0;
    tgt = 32'h0;
    if (can_redirect && jv) begin
      redirect = 1'b1; tgt = jtgt;
    end else if (can_redirect && bv && bt) begin
      redirect = 1'b1; tgt = btgt;
    end
    new_npc = redirect ? tgt : m_npc + 32'd4;
`ifdef NPC_ALIGN_CHECK_EN
    if (redirect && (tgt % 4 != 0)) begin
      new_npc = m_npc + 32'd4;
      m_mis = 1'b1;
    end
`endif
    m_annul = can_redirect && bv && bn && (!bt || ba);
    m_pc = m_npc;
    m_npc = new_npc;
  endtask

  initial begin
    vec_t v;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    vecs.push_back(mk("reset",      0,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h0,  32'h4,  0,0));
    vecs.push_back(mk("free1",      1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h4,  32'h8,  0,0));
    vecs.push_back(mk("free2",      1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h8,  32'hC,  0,0));
    vecs.push_back(mk("free3",      1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'hC,  32'h10, 0,0));
    vecs.push_back(mk("free4",      1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h10, 32'h14, 0,0));
    vecs.push_back(mk("bne_taken",  1,0, 1,1,0,0, 32'h40,  0,32'h0, 32'h14, 32'h40, 0,0));
    vecs.push_back(mk("bne_tgt",    1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h40, 32'h44, 0,0));
    vecs.push_back(mk("bne_after",  1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h44, 32'h48, 0,0));
    vecs.push_back(mk("reset2",     0,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h0,  32'h4,  0,0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk("walk",     1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'(4*i), 32'(4*i+4), 0,0));
    vecs.push_back(mk("ba_a",       1,0, 1,1,1,1, 32'h80,  0,32'h0, 32'h14, 32'h80, 1,0));
    vecs.push_back(mk("squash_ign", 1,0, 1,1,0,0, 32'h200, 1,32'h300, 32'h80, 32'h84, 0,0));
    vecs.push_back(mk("reset3",     0,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h0,  32'h4,  0,0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk("walk",     1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'(4*i), 32'(4*i+4), 0,0));
    vecs.push_back(mk("bne_a_nt",   1,0, 1,0,0,1, 32'h60,  0,32'h0, 32'h14, 32'h18, 1,0));
    vecs.push_back(mk("bne_a_nt2",  1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h18, 32'h1C, 0,0));
    vecs.push_back(mk("bne_a_tk",   1,0, 1,1,0,1, 32'h60,  0,32'h0, 32'h1C, 32'h60, 0,0));
    vecs.push_back(mk("bne_a_tk2",  1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h60, 32'h64, 0,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("stall",    1,1, 1,1,0,0, 32'h100, 0,32'h0, 32'h60, 32'h64, 0,0));
    vecs.push_back(mk("unstall",    1,0, 1,1,0,0, 32'h100, 0,32'h0, 32'h64, 32'h100,0,0));
    vecs.push_back(mk("stall_tgt",  1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h100,32'h104,0,0));
    vecs.push_back(mk("jmpl_prio",  1,0, 1,1,0,0, 32'h300, 1,32'h200, 32'h104,32'h200,0,0));
    vecs.push_back(mk("jmpl_tgt",   1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h200,32'h204,0,0));
    vecs.push_back(mk("jmpl_hi",    1,0, 0,0,0,0, 32'h0,   1,32'hFFFF_FFF8, 32'h204, 32'hFFFF_FFF8, 0,0));
    vecs.push_back(mk("hi1",        1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0,0));
    vecs.push_back(mk("wrap",       1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'hFFFF_FFFC, 32'h0, 0,0));
    vecs.push_back(mk("wrap2",      1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h0,  32'h4,  0,0));
    vecs.push_back(mk("dcti_br",    1,0, 1,1,0,0, 32'h40,  0,32'h0, 32'h4,  32'h40, 0,0));
    vecs.push_back(mk("dcti_jmpl",  1,0, 0,0,0,0, 32'h0,   1,32'h80, 32'h40, 32'h80, 0,0));
    vecs.push_back(mk("dcti_end",   1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h80, 32'h84, 0,0));
    vecs.push_back(mk("rst_pend",   0,0, 1,1,0,0, 32'h900, 0,32'h0, 32'h0,  32'h4,  0,0));
    vecs.push_back(mk("rst_drop",   1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h4,  32'h8,  0,0));
`ifdef NPC_ALIGN_CHECK_EN
    vecs.push_back(mk("mis_br",     1,0, 1,1,0,0, 32'h42,  0,32'h0, 32'h8,  32'hC,  0,1));
    vecs.push_back(mk("mis_next",   1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'hC,  32'h10, 0,1));
    vecs.push_back(mk("mis_stick",  1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h10, 32'h14, 0,1));
`else
    vecs.push_back(mk("mis_br",     1,0, 1,1,0,0, 32'h42,  0,32'h0, 32'h8,  32'h42, 0,0));
    vecs.push_back(mk("mis_next",   1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h42, 32'h46, 0,0));
    vecs.push_back(mk("mis_stick",  1,0, 0,0,0,0, 32'h0,   0,32'h0, 32'h46, 32'h4A, 0,0));
`endif
    vecs.push_back(mk("rst_stall",  0,1, 1,1,0,0, 32'h500, 1,32'h600, 32'h0, 32'h4, 0,0));

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.rst_n, v.stall, v.bv, v.bt, v.ba, v.bn, v.btgt, v.jv, v.jtgt);
      @(posedge clk);
      #1;
      $display("vec %0d %s: pc=%08h npc=%08h annul=%0b mis=%0b", i, v.name, pc_out, npc_out, annul_out, misalign);
      check32({v.name, ".pc"},  pc_out,  v.exp_pc);
      check32({v.name, ".npc"}, npc_out, v.exp_npc);
      check1({v.name, ".annul"}, annul_out, v.exp_annul);
      check1({v.name, ".mis"},   misalign,  v.exp_mis);
    end

    // Randomized phase against the reference model
    m_pc = 32'h0; m_npc = 32'h4; m_annul = 1'b0; m_mis = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    for (int c = 0; c < 3000; c++) begin
      logic        r, s, bv, bt, ba, bn, jv;
      logic [31:0] btgt, jtgt;
      @(negedge clk);
      r    = ($urandom_range(0, 99) != 0);
      s    = ($urandom_range(0, 4) == 0);
      bv   = ($urandom_range(0, 2) == 0);
      bt   = $urandom_range(0, 1);
      ba   = ($urandom_range(0, 3) == 0);
      bn   = $urandom_range(0, 1);
      jv   = ($urandom_range(0, 7) == 0);
      btgt = $urandom & 32'hFFFF_FFFC;
      jtgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) btgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) jtgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 49) == 0) begin
        btgt = 32'hFFFF_FFF8; bt = 1'b1;
      end
      drive(r, s, bv, bt, ba, bn, btgt, jv, jtgt);
      model_edge(r, s, bv, bt, ba, bn, btgt, jv, jtgt);
      @(posedge clk);
      #1;
      $display("rnd %0d: r=%0b s=%0b bv=%0b bt=%0b ba=%0b bn=%0b jv=%0b pc=%08h npc=%08h an=%0b mis=%0b",
               c, r, s, bv, bt, ba, bn, jv, pc_out, npc_out, annul_out, misalign);
      check32("rnd.pc",  pc_out,  m_pc);
      check32("rnd.npc", npc_out, m_npc);
      check1("rnd.annul", annul_out, m_annul);
      check1("rnd.mis",   misalign,  m_mis);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_sequencer.md
# npc_sequencer

SPARC PC/nPC sequencer. It consumes the branch target produced by the displacement path (sign-extend, ×4, 32-bit add) and owns the architectural PC/nPC pair. It implements delayed control transfer: the delay slot and annul bit, plus JMPL redirect. It sits at the fetch end of the pipeline, drives the instruction-memory address, and tags each fetched instruction as valid or annulled.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset; nPC resets to RESET_PC+4
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- stall  input  1  hold PC, nPC, state; all redirect inputs ignored while high
- br_valid  input  1  Bicc resolved this cycle for instruction at pc_out
- br_taken  input  1  condition evaluated true (valid with br_valid)
- br_always  input  1  branch is BA (cond 4'b1000); used for annul rule
- br_annul  input  1  a-bit of the branch instruction
- br_target  input  32  PC-relative target (disp22 sign-extended ×4 + PC)
- jmpl_valid  input  1  JMPL/RETT target resolved for instruction at pc_out
- jmpl_target  input  32  register-indirect target
- pc_out  output  32  fetch address of current instruction
- npc_out  output  32  architectural nPC
- annul_out  output  1  instruction at pc_out is annulled (must not write state)
- misalign  output  1  target[1:0]≠0 detected (only with NPC_ALIGN_CHECK_EN)

## Operation
- State machine (2 bits): RUN, SLOT, SQUASH.
  - RUN: no pending CTI effect on the current instruction.
  - SLOT: the current instruction is an executing delay slot.
  - SQUASH: the current instruction is an annulled delay slot.
- Every non-stalled edge: pc ← npc. The new npc is chosen by the first matching rule:
  - jmpl_valid → jmpl_target
  - br_valid & br_taken → br_target
  - otherwise → npc+4
- Arithmetic is 32-bit, wrap-around modulo 2^32. 32'hFFFF_FFFC + 4 = 0, with no flag.
- Priority: jmpl_valid over br_valid if both asserted.
- CTI inputs are ignored while state = SQUASH. An annulled instruction cannot redirect.
- Next state on a non-stalled edge:
  - br_valid & br_annul & (~br_taken | br_always) → SQUASH. This covers BA,a (taken but slot annulled), and Bcc,a / BN,a not taken.
  - br_valid (other cases) or jmpl_valid → SLOT
  - else → RUN
- annul_out = (state == SQUASH).
- DCTI couple (CTI accepted in SLOT): honored normally. npc is overwritten; pc follows the old npc.

## Timing
- Reset (rst_n low at edge):
  - pc_out = RESET_PC
  - npc_out = RESET_PC+4
  - state = RUN, annul_out = 0, misalign = 0
- Reset dominates stall and all CTI inputs. Reset mid-branch discards the pending target.
- Latency:
  - CTI accepted at edge N → pc_out = delay-slot address after N.
  - pc_out = target after edge N+1.
- Outputs are registered; there is no combinational path from inputs to outputs.
- stall high at an edge: pc, npc, state, misalign are unchanged. The upstream stage holds br_*/jmpl_* until stall drops.
- br_valid/jmpl_valid are single-cycle qualifiers per instruction. Holding them across two non-stalled edges counts as two CTIs.

## Configuration
- NPC_ALIGN_CHECK_EN defined:
  - An accepted redirect whose selected target has [1:0]≠0 is dropped; npc ← npc+4 instead.
  - The state machine still follows the annul rules.
  - misalign is set to 1 and stays set until reset.
- NPC_ALIGN_CHECK_EN undefined:
  - misalign is tied 0.
  - Targets are loaded unchanged, including the low bits.

## Test plan
- Reset, then 3 free edges → pc_out 0,4,8,C; npc_out 4,8,C,10; annul_out 0 throughout.
- Taken BNE (a=0), pc_out=0x10, br_target=0x40 → next pc_out 0x14 with annul_out 0, then 0x40, then 0x44.
- BA,a at pc_out=0x10, target 0x80 → pc_out 0x14 with annul_out 1; CTI asserted on that cycle is ignored; then pc_out 0x80 with annul_out 0.
- BNE,a not taken at 0x10 → pc_out 0x14 with annul_out 1, then 0x18; BNE,a taken → 0x14 with annul_out 0, then target.
- stall held 3 cycles during a taken branch → pc/npc frozen, redirect completes on the first unstalled edge. jmpl_valid and br_valid both asserted → jmpl_target wins. npc 0xFFFF_FFFC → wraps to 0.
- With NPC_ALIGN_CHECK_EN: br_target=0x42 → misalign=1, pc sequence continues 0x14, 0x18. Without the macro: pc_out reaches 0x42 and misalign stays 0.
